// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the ID->EX operand stage.
//   ALU_* : ALU operation codes. This is the encoding the ALU and the decoder also use.
//   OP1_* : operand-1 select values.
//   OP2_* : operand-2 select values. The fourth encoding is reserved and yields 0.
package id_ex_operand_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;

  localparam logic       OP1_RS1  = 1'b0;
  localparam logic       OP1_PC   = 1'b1;

  localparam logic [1:0] OP2_RS2  = 2'b00;
  localparam logic [1:0] OP2_IMM  = 2'b01;
  localparam logic [1:0] OP2_FOUR = 2'b10;

endpackage

// File: rtl/id_ex_operand_stage_ex_fwd_mux.sv
// ex_fwd_mux: EX-stage bypass for one register source. It exists only in builds that define EX_FORWARD_EN.
//   idx      : source register index held in the EX stage
//   reg_val  : value captured from the register file
//   mem_*    : destination, write enable and data of the MEM stage
//   wb_*     : destination, write enable and data of the WB stage
//   value    : bypassed operand
// The MEM stage wins over WB because it holds the younger result.
// Source x0 is never bypassed, because x0 is always zero.
`ifdef EX_FORWARD_EN
module ex_fwd_mux #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic [RF_AW-1:0] idx,
  input  logic [XLEN-1:0]  reg_val,
  input  logic [RF_AW-1:0] mem_rd,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [RF_AW-1:0] wb_rd,
  input  logic             wb_we,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  value
);

  always_comb begin
    value = reg_val;
    if (idx != '0) begin
      if (mem_we && (mem_rd == idx))
        value = mem_data;
      else if (wb_we && (wb_rd == idx))
        value = wb_data;
    end
  end

endmodule
`endif

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: the ID->EX pipeline register of the RV32I pipeline, plus the ALU operand selection.
//   Control inputs : clk, rst (synchronous, active-high), bubble (hold), flush (squash to NOP)
//   ID inputs      : pc_d, rs1_data_d, rs2_data_d, imm_d, rs1_d, rs2_d, rd_d, alu_func_d,
//                    op1_sel_d, op2_sel_d, reg_write_d, valid_d
//   Bypass inputs  : fwd_mem_*, fwd_wb_* (present only when EX_FORWARD_EN is defined)
//   Outputs        : op1, op2, alu_func (these go to the ALU)
//                    store_data_e, rd_e, reg_write_e, valid_e (these go to EX/MEM)
// Optional feature: macro EX_FORWARD_EN adds the MEM/WB bypass on rs1 and rs2.
// Without it, the hazard unit must stall instead.
// Update priority on each clock edge: rst, then flush, then bubble, then load.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic             flush,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  rs1_data_d,
  input  logic [XLEN-1:0]  rs2_data_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic [RF_AW-1:0] rs1_d,
  input  logic [RF_AW-1:0] rs2_d,
  input  logic [RF_AW-1:0] rd_d,
  input  logic [3:0]       alu_func_d,
  input  logic             op1_sel_d,
  input  logic [1:0]       op2_sel_d,
  input  logic             reg_write_d,
  input  logic             valid_d,
`ifdef EX_FORWARD_EN
  input  logic [RF_AW-1:0] fwd_mem_rd,
  input  logic             fwd_mem_we,
  input  logic [XLEN-1:0]  fwd_mem_data,
  input  logic [RF_AW-1:0] fwd_wb_rd,
  input  logic             fwd_wb_we,
  input  logic [XLEN-1:0]  fwd_wb_data,
`endif
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [3:0]       alu_func,
  output logic [XLEN-1:0]  store_data_e,
  output logic [RF_AW-1:0] rd_e,
  output logic             reg_write_e,
  output logic             valid_e
);

  logic [XLEN-1:0]  pc_e, rs1_data_e, rs2_data_e, imm_e;
  logic             op1_sel_e, reg_write_q;
  logic [1:0]       op2_sel_e;
  logic [XLEN-1:0]  rs1v, rs2v;

  function automatic logic [XLEN-1:0] op2_pick(input logic [1:0] sel, input logic [XLEN-1:0] rs2,
                                               input logic [XLEN-1:0] imm);
    case (sel)
      OP2_RS2:  op2_pick = rs2;
      OP2_IMM:  op2_pick = imm;
      OP2_FOUR: op2_pick = XLEN'(4);
      default:  op2_pick = '0;
    endcase
  endfunction

  // ---- ID -> EX stage register ----
  // The data registers are cleared together with the control registers.
  // A squashed slot then shows op1 = op2 = 0, which is the same value seen after reset.
`ifdef EX_FORWARD_EN
  logic [RF_AW-1:0] rs1_e, rs2_e;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rs1_e <= '0;
      rs2_e <= '0;
    end else if (!bubble) begin
      rs1_e <= rs1_d;
      rs2_e <= rs2_d;
    end
  end
`else
  // Without the bypass, the source indices are not needed past ID.
  logic unused_idx;
  assign unused_idx = ^{rs1_d, rs2_d};
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_e     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_e        <= '0;
      pc_e        <= '0;
      rs1_data_e  <= '0;
      rs2_data_e  <= '0;
      imm_e       <= '0;
      alu_func    <= ALU_ADD;
      op1_sel_e   <= OP1_RS1;
      op2_sel_e   <= OP2_RS2;
    end else if (!bubble) begin
      valid_e     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_e        <= rd_d;
      pc_e        <= pc_d;
      rs1_data_e  <= rs1_data_d;
      rs2_data_e  <= rs2_data_d;
      imm_e       <= imm_d;
      alu_func    <= alu_func_d;
      op1_sel_e   <= op1_sel_d;
      op2_sel_e   <= op2_sel_d;
    end
  end

  // ---- EX: bypass, then operand mux ----
`ifdef EX_FORWARD_EN
  ex_fwd_mux #(.XLEN(XLEN), .RF_AW(RF_AW)) u_fwd_rs1 (
    .idx(rs1_e), .reg_val(rs1_data_e),
    .mem_rd(fwd_mem_rd), .mem_we(fwd_mem_we), .mem_data(fwd_mem_data),
    .wb_rd(fwd_wb_rd), .wb_we(fwd_wb_we), .wb_data(fwd_wb_data),
    .value(rs1v)
  );

  ex_fwd_mux #(.XLEN(XLEN), .RF_AW(RF_AW)) u_fwd_rs2 (
    .idx(rs2_e), .reg_val(rs2_data_e),
    .mem_rd(fwd_mem_rd), .mem_we(fwd_mem_we), .mem_data(fwd_mem_data),
    .wb_rd(fwd_wb_rd), .wb_we(fwd_wb_we), .wb_data(fwd_wb_data),
    .value(rs2v)
  );
`else
  assign rs1v = rs1_data_e;
  assign rs2v = rs2_data_e;
`endif

  assign op1          = (op1_sel_e == OP1_PC) ? pc_e : rs1v;
  assign op2          = op2_pick(op2_sel_e, rs2v, imm_e);
  assign store_data_e = rs2v;
  // rd == x0 is deliberately not masked here, because the register file ignores writes to x0.
  assign reg_write_e  = reg_write_q & valid_e;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  typedef struct {
    logic             valid;
    logic             rw;
    logic [RF_AW-1:0] rd;
    logic [3:0]       func;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [XLEN-1:0]  sd;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, bubble, flush;
  logic [XLEN-1:0]  pc_d, rs1_data_d, rs2_data_d, imm_d;
  logic [RF_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [3:0]       alu_func_d;
  logic             op1_sel_d;
  logic [1:0]       op2_sel_d;
  logic             reg_write_d, valid_d;
  logic [RF_AW-1:0] fwd_mem_rd, fwd_wb_rd;
  logic             fwd_mem_we, fwd_wb_we;
  logic [XLEN-1:0]  fwd_mem_data, fwd_wb_data;
  logic [XLEN-1:0]  op1, op2, store_data_e;
  logic [3:0]       alu_func;
  logic [RF_AW-1:0] rd_e;
  logic             reg_write_e, valid_e;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
    .clk(clk), .rst(rst), .bubble(bubble), .flush(flush),
    .pc_d(pc_d), .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_func_d(alu_func_d),
    .op1_sel_d(op1_sel_d), .op2_sel_d(op2_sel_d), .reg_write_d(reg_write_d), .valid_d(valid_d),
`ifdef EX_FORWARD_EN
    .fwd_mem_rd(fwd_mem_rd), .fwd_mem_we(fwd_mem_we), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_rd(fwd_wb_rd), .fwd_wb_we(fwd_wb_we), .fwd_wb_data(fwd_wb_data),
`endif
    .op1(op1), .op2(op2), .alu_func(alu_func), .store_data_e(store_data_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .valid_e(valid_e)
  );

  function automatic exp_t mk(input string name, input logic v, input logic rw,
                              input logic [RF_AW-1:0] rd, input logic [3:0] func,
                              input logic [XLEN-1:0] o1, input logic [XLEN-1:0] o2,
                              input logic [XLEN-1:0] sd);
    exp_t e;
    e.name = name; e.valid = v; e.rw = rw; e.rd = rd; e.func = func;
    e.op1 = o1; e.op2 = o2; e.sd = sd;
    return e;
  endfunction

  // Monitor: each expected entry is consumed at the falling edge after the capturing rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (valid_e !== e.valid || reg_write_e !== e.rw || rd_e !== e.rd || alu_func !== e.func ||
          op1 !== e.op1 || op2 !== e.op2 || store_data_e !== e.sd) begin
        n_bad++;
        $display("FAIL %s: got v=%0b rw=%0b rd=%0d f=%0h op1=%h op2=%h sd=%h, expected v=%0b rw=%0b rd=%0d f=%0h op1=%h op2=%h sd=%h",
                 e.name, valid_e, reg_write_e, rd_e, alu_func, op1, op2, store_data_e,
                 e.valid, e.rw, e.rd, e.func, e.op1, e.op2, e.sd);
      end
    end
  end

  task automatic clear_ins();
    rst = 0; bubble = 0; flush = 0;
    pc_d = '0; rs1_data_d = '0; rs2_data_d = '0; imm_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; alu_func_d = ALU_ADD;
    op1_sel_d = OP1_RS1; op2_sel_d = OP2_RS2; reg_write_d = 0; valid_d = 0;
    fwd_mem_rd = '0; fwd_mem_we = 0; fwd_mem_data = '0;
    fwd_wb_rd = '0; fwd_wb_we = 0; fwd_wb_data = '0;
  endtask

  task automatic load(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                      input logic [XLEN-1:0] imm, input logic [RF_AW-1:0] rd, input logic [3:0] f,
                      input logic s1, input logic [1:0] s2, input logic rw, input logic v);
    pc_d = pc; rs1_data_d = r1; rs2_data_d = r2; imm_d = imm; rd_d = rd; alu_func_d = f;
    op1_sel_d = s1; op2_sel_d = s2; reg_write_d = rw; valid_d = v;
  endtask

  // Present the inputs over one rising edge, then queue what the outputs must show.
  task automatic tick(input exp_t e);
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clear_ins();
    #1;
    // Reset with garbage inputs.
    rst = 1; bubble = 1;
    load(32'hDEAD_BEEF, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 5'd31, ALU_SRA, 1, 2'b01, 1, 1);
    rs1_d = 5'd7; rs2_d = 5'd9;
    tick(mk("reset", 0, 0, 0, ALU_ADD, 0, 0, 0));

    clear_ins();
    load(32'h0, 32'h10, 32'h20, 32'h0, 5'd3, ALU_SUB, OP1_RS1, OP2_RS2, 1, 1);
    tick(mk("load_sub", 1, 1, 3, ALU_SUB, 32'h10, 32'h20, 32'h20));

    load(32'h44, 32'h5, 32'h66, 32'h123, 5'd7, ALU_AND, OP1_RS1, OP2_IMM, 1, 0);
    tick(mk("imm_invalid", 0, 0, 7, ALU_AND, 32'h5, 32'h123, 32'h66));

    load(32'h44, 32'h8, 32'h99, 32'h55, 5'd8, ALU_OR, OP1_RS1, 2'b11, 0, 1);
    tick(mk("op2_reserved", 1, 0, 8, ALU_OR, 32'h8, 32'h0, 32'h99));

    load(32'h1000, 32'h3, 32'h77, 32'h0, 5'd9, ALU_ADD, OP1_PC, OP2_FOUR, 1, 1);
    tick(mk("pc_plus4", 1, 1, 9, ALU_ADD, 32'h1000, 32'h4, 32'h77));

    bubble = 1;
    for (int i = 0; i < 3; i++) begin
      load(32'h2000 + i, 32'hA0 + i, 32'hB0 + i, 32'hC0, 5'(20 + i), ALU_XOR, OP1_RS1, OP2_IMM, 0, i[0]);
      tick(mk("bubble_hold", 1, 1, 9, ALU_ADD, 32'h1000, 32'h4, 32'h77));
    end

    bubble = 0;
    load(32'h3000, 32'hFFFF_FFF0, 32'h1, 32'h0, 5'd12, ALU_SLT, OP1_RS1, OP2_RS2, 1, 1);
    tick(mk("after_bubble", 1, 1, 12, ALU_SLT, 32'hFFFF_FFF0, 32'h1, 32'h1));

    flush = 1; bubble = 1;
    load(32'h4000, 32'h11, 32'h22, 32'h33, 5'd13, ALU_SUB, OP1_PC, OP2_IMM, 1, 1);
    tick(mk("flush_bubble", 0, 0, 0, ALU_ADD, 0, 0, 0));

    flush = 0; bubble = 0;
    load(32'h0, 32'h0, 32'h5, 32'h0, 5'd0, ALU_SLL, OP1_RS1, OP2_RS2, 1, 1);
    tick(mk("rd_x0_kept", 1, 1, 0, ALU_SLL, 32'h0, 32'h5, 32'h5));

    flush = 1;
    tick(mk("flush_only", 0, 0, 0, ALU_ADD, 0, 0, 0));

    flush = 0;
    load(32'h500, 32'h1, 32'h2, 32'h3, 5'd14, ALU_SRL, OP1_PC, OP2_IMM, 1, 1);
    tick(mk("reload", 1, 1, 14, ALU_SRL, 32'h500, 32'h3, 32'h2));

    rst = 1;
    tick(mk("mid_reset", 0, 0, 0, ALU_ADD, 0, 0, 0));

    rst = 0;
    load(32'h600, 32'h21, 32'h42, 32'h0, 5'd15, ALU_SLTU, OP1_RS1, OP2_RS2, 1, 1);
    tick(mk("post_reset_load", 1, 1, 15, ALU_SLTU, 32'h21, 32'h42, 32'h42));

`ifdef EX_FORWARD_EN
    clear_ins();
    load(32'h0, 32'h1, 32'h0, 32'h0, 5'd1, ALU_ADD, OP1_RS1, OP2_RS2, 1, 1);
    rs1_d = 5'd5;
    fwd_mem_rd = 5'd5; fwd_mem_we = 1; fwd_mem_data = 32'hAA;
    fwd_wb_rd  = 5'd5; fwd_wb_we  = 1; fwd_wb_data  = 32'hBB;
    tick(mk("fwd_mem_prio", 1, 1, 1, ALU_ADD, 32'hAA, 32'h0, 32'h0));

    fwd_mem_we = 0;
    tick(mk("fwd_wb", 1, 1, 1, ALU_ADD, 32'hBB, 32'h0, 32'h0));

    rs1_d = 5'd0; rs1_data_d = 32'h0;
    fwd_mem_rd = 5'd0; fwd_mem_we = 1; fwd_mem_data = 32'hAA;
    fwd_wb_rd = 5'd0; fwd_wb_we = 1;
    tick(mk("fwd_x0", 1, 1, 1, ALU_ADD, 32'h0, 32'h0, 32'h0));

    clear_ins();
    load(32'h0, 32'h3, 32'h9, 32'h7FF, 5'd2, ALU_ADD, OP1_RS1, OP2_IMM, 0, 1);
    rs1_d = 5'd4; rs2_d = 5'd6;
    fwd_mem_rd = 5'd6; fwd_mem_we = 1; fwd_mem_data = 32'hCAFE;
    tick(mk("fwd_store_imm", 1, 0, 2, ALU_ADD, 32'h3, 32'h7FF, 32'hCAFE));
`endif

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left in queue, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
